// File: rtl/mcu_bus_pkg.sv
// Shared types and constants for the MCU bus fabric.
//   bus_state_e : fabric FSM states (idle, slave access in flight, response pulse)
//   Def*        : default address/data widths and region-index field placement
//   ERR_CNT_W   : width of the saturating error-response counter
package mcu_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } bus_state_e;

  localparam int unsigned DefAw    = 32;
  localparam int unsigned DefDw    = 32;
  localparam int unsigned DefDecLo = 8;
  localparam int unsigned DefDecW  = 8;

  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/mcu_bus_decoder.sv
// Combinational address decoder for the MCU bus fabric.
// The region index is addr_i[DEC_LO+DEC_W-1:DEC_LO]. Indices below N_SLV map one-to-one
// onto slave ports; anything else is unmapped.
//   addr_i   : byte address
//   sel_o    : one-hot slave select, all zero when unmapped
//   mapped_o : 1 when the index addresses an existing slave
module mcu_bus_decoder
  import mcu_bus_pkg::*;
#(
  parameter int unsigned N_SLV  = 4,
  parameter int unsigned AW     = DefAw,
  parameter int unsigned DEC_LO = DefDecLo,
  parameter int unsigned DEC_W  = DefDecW
) (
  input  logic [AW-1:0]    addr_i,
  output logic [N_SLV-1:0] sel_o,
  output logic             mapped_o
);

  logic [DEC_W-1:0] idx;
  logic [31:0]      idx_ext;
  logic             unused_addr;

  assign idx         = addr_i[DEC_LO+DEC_W-1:DEC_LO];
  assign idx_ext     = 32'(idx);
  // Only the index field is decoded; the remaining address bits are don't-care here.
  assign unused_addr = ^addr_i;

  always_comb begin
    mapped_o = (idx_ext < N_SLV);
    sel_o    = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      sel_o[i] = mapped_o && (idx_ext == i);
    end
  end

endmodule

// File: rtl/mcu_bus_fabric.sv
// Single-master bus fabric: decodes the master address onto N_SLV slave ports with a
// registered request/ready handshake, per-slave wait states, access timeout and error
// responses. All outputs are registered.
//   clk, rst          : clock and synchronous active-high reset
//   m_req/m_we/m_addr/m_wdata : master request, held until m_ready
//   m_ready/m_rdata/m_err     : one-cycle response pulse with data and error flag
//   s_sel/s_we/s_addr/s_wdata : one-hot select and registered request to the slaves
//   s_rdata/s_ready           : flattened slave read data and per-slave completion
//   err_cnt                   : saturating count of error responses
module mcu_bus_fabric
  import mcu_bus_pkg::*;
#(
  parameter int unsigned N_SLV   = 4,
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned DEC_LO  = DefDecLo,
  parameter int unsigned DEC_W   = DefDecW,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m_req,
  input  logic                 m_we,
  input  logic [AW-1:0]        m_addr,
  input  logic [DW-1:0]        m_wdata,
  output logic                 m_ready,
  output logic [DW-1:0]        m_rdata,
  output logic                 m_err,
  output logic [N_SLV-1:0]     s_sel,
  output logic                 s_we,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_wdata,
  input  logic [N_SLV*DW-1:0]  s_rdata,
  input  logic [N_SLV-1:0]     s_ready,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned CntW = 8;

  bus_state_e           state_q;
  logic [CntW-1:0]      cnt_q;
  logic                 m_ready_q, m_err_q, s_we_q;
  logic [DW-1:0]        m_rdata_q, s_wdata_q;
  logic [AW-1:0]        s_addr_q;
  logic [N_SLV-1:0]     s_sel_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic [N_SLV-1:0] dec_sel;
  logic             dec_mapped;
  logic             sel_ready;
  logic [DW-1:0]    sel_rdata;

  mcu_bus_decoder #(
    .N_SLV  (N_SLV),
    .AW     (AW),
    .DEC_LO (DEC_LO),
    .DEC_W  (DEC_W)
  ) u_decoder (
    .addr_i   (m_addr),
    .sel_o    (dec_sel),
    .mapped_o (dec_mapped)
  );

  // The registered one-hot select doubles as the index of the slave in flight, so
  // unselected ready bits and read data are masked off here.
  always_comb begin
    sel_ready = |(s_ready & s_sel_q);
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (s_sel_q[i]) begin
        sel_rdata = sel_rdata | s_rdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      m_ready_q <= 1'b0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
      s_sel_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      err_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m_req) begin
            if (dec_mapped) begin
              s_sel_q   <= dec_sel;
              s_we_q    <= m_we;
              s_addr_q  <= m_addr;
              s_wdata_q <= m_wdata;
              cnt_q     <= '0;
              state_q   <= StAccess;
            end else begin
              m_err_q   <= 1'b1;
              m_rdata_q <= '0;
              m_ready_q <= 1'b1;
              state_q   <= StResp;
            end
          end
        end
        StAccess: begin
          // Ready is checked first so it wins over a coincident timeout.
          if (sel_ready) begin
            m_rdata_q <= s_we_q ? '0 : sel_rdata;
            m_err_q   <= 1'b0;
            s_sel_q   <= '0;
            m_ready_q <= 1'b1;
            state_q   <= StResp;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            m_rdata_q <= '0;
            m_err_q   <= 1'b1;
            s_sel_q   <= '0;
            m_ready_q <= 1'b1;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          if (m_err_q && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
          end
          m_ready_q <= 1'b0;
          m_err_q   <= 1'b0;
          m_rdata_q <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_ready = m_ready_q;
  assign m_err   = m_err_q;
  assign m_rdata = m_rdata_q;
  assign s_sel   = s_sel_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mcu_bus_fabric.sv
// Directed self-checking bench for mcu_bus_fabric (N_SLV=4, TIMEOUT=16).
// Inputs change and outputs are sampled on the falling edge; "cycle k" is the k-th
// falling edge after the rising edge that samples m_req.
module tb_mcu_bus_fabric;

  localparam int unsigned NSlv    = 4;
  localparam int unsigned Aw      = 32;
  localparam int unsigned Dw      = 32;
  localparam int unsigned Timeout = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 m_req = 1'b0;
  logic                 m_we = 1'b0;
  logic [Aw-1:0]        m_addr = '0;
  logic [Dw-1:0]        m_wdata = '0;
  logic                 m_ready;
  logic [Dw-1:0]        m_rdata;
  logic                 m_err;
  logic [NSlv-1:0]      s_sel;
  logic                 s_we;
  logic [Aw-1:0]        s_addr;
  logic [Dw-1:0]        s_wdata;
  logic [NSlv*Dw-1:0]   s_rdata;
  logic [NSlv-1:0]      s_ready = '0;
  logic [7:0]           err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Results of the most recent do_txn call.
  logic [NSlv-1:0] r_sel_or;
  int              r_sel_cycles;
  int              r_ready_cyc;
  logic [Dw-1:0]   r_rdata;
  logic            r_err;
  logic            r_we;
  logic [Dw-1:0]   r_wdata;
  logic [Aw-1:0]   r_addr;

  mcu_bus_fabric #(
    .N_SLV   (NSlv),
    .AW      (Aw),
    .DW      (Dw),
    .DEC_LO  (8),
    .DEC_W   (8),
    .TIMEOUT (Timeout)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .m_err   (m_err),
    .s_sel   (s_sel),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .s_ready (s_ready),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // One master transaction. Slave `slv` asserts ready once s_sel[slv] has been high for
  // more than `waits` cycles; waits < 0 means the slave never answers.
  task automatic do_txn(input logic we, input logic [Aw-1:0] addr, input logic [Dw-1:0] wdata,
                        input int slv, input int waits);
    @(negedge clk);
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; s_ready = '0;
    r_sel_or = '0; r_sel_cycles = 0; r_ready_cyc = -1;
    r_rdata = 'x; r_err = 1'bx; r_we = 1'bx; r_wdata = 'x; r_addr = 'x;
    for (int cyc = 1; cyc <= 40 && r_ready_cyc < 0; cyc++) begin
      @(negedge clk);
      r_sel_or = r_sel_or | s_sel;
      if (s_sel != '0) begin
        r_sel_cycles++;
        r_we = s_we; r_wdata = s_wdata; r_addr = s_addr;
      end
      if (m_ready) begin
        r_ready_cyc = cyc; r_rdata = m_rdata; r_err = m_err;
        m_req = 1'b0;
      end
      s_ready = '0;
      if (waits >= 0 && s_sel[slv] && r_sel_cycles > waits) s_ready[slv] = 1'b1;
    end
    m_req = 1'b0;
    s_ready = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL rst_m_ready: got %b want 0", m_ready); end
    n_tests++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL rst_m_err: got %b want 0", m_err); end
    n_tests++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_m_rdata: got %h want 0", m_rdata); end
    n_tests++; if (s_sel !== 4'b0) begin n_fail++; $display("FAIL rst_s_sel: got %b want 0", s_sel); end
    n_tests++; if ({s_we, s_addr, s_wdata} !== 65'h0) begin
      n_fail++; $display("FAIL rst_s_regs: got we=%b addr=%h wdata=%h want all 0", s_we, s_addr, s_wdata);
    end
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait_read();
    do_txn(1'b0, 32'h0000_0104, 32'h0, 1, 0);
    n_tests++; if (r_sel_or !== 4'b0010) begin n_fail++; $display("FAIL zw_sel: got %b want 0010", r_sel_or); end
    n_tests++; if (r_sel_cycles != 1) begin n_fail++; $display("FAIL zw_sel_cycles: got %0d want 1", r_sel_cycles); end
    n_tests++; if (r_ready_cyc != 2) begin n_fail++; $display("FAIL zw_ready_cycle: got %0d want 2", r_ready_cyc); end
    n_tests++; if (r_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL zw_rdata: got %h want cafe0001", r_rdata); end
    n_tests++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL zw_err: got %b want 0", r_err); end
    n_tests++; if (r_addr !== 32'h0000_0104) begin n_fail++; $display("FAIL zw_s_addr: got %h want 00000104", r_addr); end
  endtask

  task automatic test_wait_write();
    do_txn(1'b1, 32'h0000_0200, 32'h0000_00A5, 2, 3);
    n_tests++; if (r_we !== 1'b1) begin n_fail++; $display("FAIL ww_s_we: got %b want 1", r_we); end
    n_tests++; if (r_wdata !== 32'hA5) begin n_fail++; $display("FAIL ww_s_wdata: got %h want 000000a5", r_wdata); end
    n_tests++; if (r_sel_or !== 4'b0100) begin n_fail++; $display("FAIL ww_sel: got %b want 0100", r_sel_or); end
    n_tests++; if (r_sel_cycles != 4) begin n_fail++; $display("FAIL ww_sel_cycles: got %0d want 4", r_sel_cycles); end
    n_tests++; if (r_ready_cyc != 5) begin n_fail++; $display("FAIL ww_ready_cycle: got %0d want 5", r_ready_cyc); end
    n_tests++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL ww_rdata: got %h want 0", r_rdata); end
    n_tests++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL ww_err: got %b want 0", r_err); end
  endtask

  task automatic test_unmapped();
    do_txn(1'b0, 32'h0000_0700, 32'h0, 0, 0);
    n_tests++; if (r_sel_or !== 4'b0) begin n_fail++; $display("FAIL um_sel: got %b want 0", r_sel_or); end
    n_tests++; if (r_ready_cyc != 1) begin n_fail++; $display("FAIL um_ready_cycle: got %0d want 1", r_ready_cyc); end
    n_tests++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL um_err: got %b want 1", r_err); end
    n_tests++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL um_rdata: got %h want 0", r_rdata); end
    @(negedge clk);
    n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL um_err_cnt: got %0d want 1", err_cnt); end
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 32'h0000_0300, 32'h0, 3, -1);
    n_tests++; if (r_sel_or !== 4'b1000) begin n_fail++; $display("FAIL to_sel: got %b want 1000", r_sel_or); end
    n_tests++; if (r_sel_cycles != 16) begin n_fail++; $display("FAIL to_sel_cycles: got %0d want 16", r_sel_cycles); end
    n_tests++; if (r_ready_cyc != 17) begin n_fail++; $display("FAIL to_ready_cycle: got %0d want 17", r_ready_cyc); end
    n_tests++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", r_err); end
    n_tests++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", r_rdata); end
    @(negedge clk);
    n_tests++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL to_err_cnt: got %0d want 2", err_cnt); end
    // Ready arrives on the 16th access cycle, the same edge the timeout would fire.
    do_txn(1'b0, 32'h0000_0300, 32'h0, 3, 15);
    n_tests++; if (r_sel_cycles != 16) begin n_fail++; $display("FAIL co_sel_cycles: got %0d want 16", r_sel_cycles); end
    n_tests++; if (r_ready_cyc != 17) begin n_fail++; $display("FAIL co_ready_cycle: got %0d want 17", r_ready_cyc); end
    n_tests++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL co_err: got %b want 0", r_err); end
    n_tests++; if (r_rdata !== 32'hCAFE_0003) begin n_fail++; $display("FAIL co_rdata: got %h want cafe0003", r_rdata); end
    @(negedge clk);
    n_tests++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL co_err_cnt: got %0d want 2", err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] pulses;
    pulses = '0;
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0010; s_ready = 4'b0001;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      pulses[cyc-1] = m_ready;
      if (cyc == 2) begin
        n_tests++; if (m_rdata !== 32'hCAFE_0000) begin n_fail++; $display("FAIL b2b_rdata: got %h want cafe0000", m_rdata); end
      end
    end
    m_req = 1'b0; s_ready = '0;
    n_tests++; if (pulses !== 9'b010010010) begin n_fail++; $display("FAIL b2b_pulses: got %b want 010010010", pulses); end
  endtask

  task automatic test_reset_mid();
    int stray;
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0300;
    @(negedge clk);
    m_req = 1'b0;
    @(negedge clk);
    n_tests++; if (s_sel !== 4'b1000) begin n_fail++; $display("FAIL rm_pre_sel: got %b want 1000", s_sel); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (s_sel !== 4'b0) begin n_fail++; $display("FAIL rm_sel: got %b want 0", s_sel); end
    n_tests++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready: got %b want 0", m_ready); end
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rm_err_cnt: got %0d want 0", err_cnt); end
    stray = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (m_ready !== 1'b0 || s_sel !== 4'b0) stray++;
    end
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL rm_no_resp: got %0d active cycles want 0", stray); end
    do_txn(1'b0, 32'h0000_0208, 32'h0, 2, 0);
    n_tests++; if (r_rdata !== 32'hCAFE_0002) begin n_fail++; $display("FAIL rm_after_rdata: got %h want cafe0002", r_rdata); end
    n_tests++; if (r_ready_cyc != 2) begin n_fail++; $display("FAIL rm_after_ready: got %0d want 2", r_ready_cyc); end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 254; n++) do_txn(1'b0, 32'h0000_FF00, 32'h0, 0, 0);
    @(negedge clk);
    n_tests++; if (err_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d want 254", err_cnt); end
    do_txn(1'b0, 32'h0000_FF00, 32'h0, 0, 0);
    @(negedge clk);
    n_tests++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d want 255", err_cnt); end
    for (int n = 0; n < 45; n++) do_txn(1'b0, 32'h0000_0400, 32'h0, 0, 0);
    n_tests++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL sat_last_err: got %b want 1", r_err); end
    @(negedge clk);
    n_tests++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", err_cnt); end
  endtask

  initial begin
    for (int i = 0; i < int'(NSlv); i++) s_rdata[i*Dw +: Dw] = 32'hCAFE_0000 + 32'(i);
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
